// File: rtl/mycpu_pkg.sv
// Shared definitions for the myCPU pipeline: memory/write-back FSM encoding,
// the zero register and the control-bit positions used by decode and mem/wb.
package mycpu_pkg;

   typedef enum logic [1:0] {
      MW_IDLE = 2'd0,
      MW_REQ  = 2'd1,
      MW_RESP = 2'd2
   } mw_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Packed control vector layout: {C6, C5, C3}
   localparam int CTRL_W = 3;
   localparam int C3_BIT = 0;
   localparam int C5_BIT = 1;
   localparam int C6_BIT = 2;

endpackage

// File: rtl/mycpu_wb_reg.sv
// Registered register-file write port: one-cycle wen pulse with r0
// suppression, address/data held between writes, and the retire counter.
module mycpu_wb_reg
   import mycpu_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_write,
   input  logic             i_wen_req,
   input  logic [4:0]       i_waddr,
   input  logic [31:0]      i_wdata,
   input  logic             i_retire,
   output logic             o_wen,
   output logic [4:0]       o_waddr,
   output logic [31:0]      o_wdata,
   output logic [CNT_W-1:0] o_retire_cnt
);

   logic             r_wen;
   logic [4:0]       r_waddr;
   logic [31:0]      r_wdata;
   logic [CNT_W-1:0] r_retire_cnt;
   logic             w_do_write;

   assign w_do_write = i_write & i_wen_req & (i_waddr != REG_ZERO);

   // Address and data only move on a real write so they hold otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wen        <= 1'b0;
         r_waddr      <= 5'd0;
         r_wdata      <= 32'd0;
         r_retire_cnt <= '0;
      end else begin
         r_wen <= w_do_write;
         if (w_do_write) begin
            r_waddr <= i_waddr;
            r_wdata <= i_wdata;
         end
         if (i_retire) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
         end
      end
   end

   assign o_wen        = r_wen;
   assign o_waddr      = r_waddr;
   assign o_wdata      = r_wdata;
   assign o_retire_cnt = r_retire_cnt;

endmodule

// File: rtl/mycpu_mem_wb.sv
// Memory-access and write-back stage: word loads/stores over a req/gnt/rvalid
// data-memory port, one memory operation in flight, then register-file write.
module mycpu_mem_wb
   import mycpu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       alu_result,
   input  logic [31:0]       store_data,
   input  logic [4:0]        target_reg,
   input  logic              c3,
   input  logic              c5,
   input  logic              c6,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_wdata,
   input  logic              dm_gnt,
   input  logic              dm_rvalid,
   input  logic [31:0]       dm_rdata,
   output logic              wen,
   output logic [4:0]        waddr,
   output logic [31:0]       wdata,
   output logic              addr_err,
   output logic [CNT_W-1:0]  retire_cnt
);

   mw_state_t         r_state;
   mw_state_t         w_next;
   logic              r_dm_req;
   logic              r_dm_we;
   logic [ADDR_W-1:0] r_dm_addr;
   logic [31:0]       r_dm_wdata;
   logic [4:0]        r_target;
   logic [CTRL_W-1:0] r_ctrl;
   logic              r_addr_err;

   logic [CTRL_W-1:0] w_ctrl_in;
   logic              w_accept;
   logic              w_is_mem;
   logic              w_misalign;
   logic              w_mem_start;
   logic              w_mis_accept;
   logic              w_alu_accept;
   logic              w_req_gnt;
   logic              w_store_done;
   logic              w_load_done;
   logic              w_wb_write;
   logic              w_wb_wen_req;
   logic [4:0]        w_wb_waddr;
   logic [31:0]       w_wb_wdata;
   logic              w_retire;

   always_comb begin
      w_ctrl_in         = '0;
      w_ctrl_in[C3_BIT] = c3;
      w_ctrl_in[C5_BIT] = c5;
      w_ctrl_in[C6_BIT] = c6;
   end

   assign in_ready     = (r_state == MW_IDLE);
   assign w_accept     = in_valid & in_ready;
   assign w_is_mem     = c3 | c6;
   assign w_misalign   = (alu_result[1:0] != 2'b00);
   assign w_mem_start  = w_accept & w_is_mem & ~w_misalign;
   assign w_mis_accept = w_accept & w_is_mem & w_misalign;
   assign w_alu_accept = w_accept & ~w_is_mem;

   // c6 wins over c3, so a latched store never takes the load path
   assign w_req_gnt    = (r_state == MW_REQ) & dm_gnt;
   assign w_store_done = w_req_gnt & r_ctrl[C6_BIT];
   assign w_load_done  = (w_req_gnt & r_ctrl[C3_BIT] & ~r_ctrl[C6_BIT] & dm_rvalid)
                       | ((r_state == MW_RESP) & dm_rvalid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= MW_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         MW_IDLE: begin
            if (w_mem_start) begin
               w_next = MW_REQ;
            end
         end
         MW_REQ: begin
            if (dm_gnt) begin
               if (r_ctrl[C6_BIT] || dm_rvalid) begin
                  w_next = MW_IDLE;
               end else begin
                  w_next = MW_RESP;
               end
            end
         end
         MW_RESP: begin
            if (dm_rvalid) begin
               w_next = MW_IDLE;
            end
         end
         default: w_next = MW_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dm_req   <= 1'b0;
         r_dm_we    <= 1'b0;
         r_dm_addr  <= '0;
         r_dm_wdata <= 32'd0;
         r_target   <= 5'd0;
         r_ctrl     <= '0;
         r_addr_err <= 1'b0;
      end else begin
         r_addr_err <= w_mis_accept;
         if (w_mem_start) begin
            r_dm_req   <= 1'b1;
            r_dm_we    <= c6;
            r_dm_addr  <= ADDR_W'(alu_result);
            r_dm_wdata <= store_data;
            r_target   <= target_reg;
            r_ctrl     <= w_ctrl_in;
         end else if (w_req_gnt) begin
            r_dm_req <= 1'b0;
         end
      end
   end

   // ALU results come straight from the inputs; loads use the latched target
   assign w_wb_write   = w_alu_accept | w_load_done;
   assign w_wb_wen_req = w_alu_accept ? c5 : r_ctrl[C5_BIT];
   assign w_wb_waddr   = w_alu_accept ? target_reg : r_target;
   assign w_wb_wdata   = w_alu_accept ? alu_result : dm_rdata;
   assign w_retire     = w_wb_write | w_store_done | w_mis_accept;

   mycpu_wb_reg #(
      .CNT_W (CNT_W)
   ) u_wb_reg (
      .clk          (clk),
      .rst          (rst),
      .i_write      (w_wb_write),
      .i_wen_req    (w_wb_wen_req),
      .i_waddr      (w_wb_waddr),
      .i_wdata      (w_wb_wdata),
      .i_retire     (w_retire),
      .o_wen        (wen),
      .o_waddr      (waddr),
      .o_wdata      (wdata),
      .o_retire_cnt (retire_cnt)
   );

   assign dm_req   = r_dm_req;
   assign dm_we    = r_dm_we;
   assign dm_addr  = r_dm_addr;
   assign dm_wdata = r_dm_wdata;
   assign addr_err = r_addr_err;

endmodule

// File: doc/mycpu_mem_wb.md
# mycpu_mem_wb

Memory-access and write-back stage of the myCPU pipeline, the producer side of the decode stage's register-file write port. It accepts one executed instruction per handshake: ALU result, store data, target register and the C3/C5/C6 controls. It performs word loads and stores on a valid/grant/response data-memory interface, then drives `wen`/`waddr`/`wdata` into the register file. At most one memory instruction is in flight at a time; back-pressure reaches the execute stage through `in_ready`.

## Interface
- `ADDR_W`, default 32: data-memory address width.
- `CNT_W`, default 32: retire-counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  execute stage offers an instruction.
- `in_ready`  out  1  stage can accept; transfer when both are high.
- `alu_result`  in  32  ALU output or effective address.
- `store_data`  in  32  rt contents for SW.
- `target_reg`  in  5  destination register.
- `c3`  in  1  1 = load (mem->reg).
- `c5`  in  1  register-file write enable request.
- `c6`  in  1  1 = store.
- `dm_req`  out  1  memory request valid.
- `dm_we`  out  1  1 = write.
- `dm_addr`  out  ADDR_W  word address, bits [1:0] = 0.
- `dm_wdata`  out  32  store data.
- `dm_gnt`  in  1  request accepted this cycle.
- `dm_rvalid`  in  1  load data valid.
- `dm_rdata`  in  32  load data.
- `wen`  out  1  register-file write strobe.
- `waddr`  out  5  register-file write address.
- `wdata`  out  32  register-file write data.
- `addr_err`  out  1  one-cycle pulse on misaligned load/store.
- `retire_cnt`  out  CNT_W  count of completed instructions.

## Operation
- FSM states: IDLE, REQ, RESP.
- `in_ready` = (state == IDLE).
- Accept in IDLE, non-memory instruction (c3 = 0, c6 = 0):
  - stay in IDLE;
  - next cycle `wen` = c5 & (target_reg != 0), `waddr` = target_reg, `wdata` = alu_result.
- Accept in IDLE, memory instruction:
  - latch address, store data, target, c3, c5 and c6;
  - go to REQ.
- Misaligned memory instruction (alu_result[1:0] != 0):
  - no memory request and no register write;
  - `addr_err` high the next cycle;
  - stay in IDLE; the instruction still retires.
- REQ:
  - `dm_req` = 1, `dm_we` = latched c6, address and data held stable until `dm_gnt`.
  - Store granted: go to IDLE; the store retires that cycle.
  - Load granted without `dm_rvalid`: go to RESP.
  - Load granted with `dm_rvalid` in the same cycle: treat as a response; go to IDLE.
- RESP: wait for `dm_rvalid`, then go to IDLE. The write next cycle is `wen` = c5 & (target != 0), `wdata` = dm_rdata.
- Writes to r0 are always suppressed; the instruction still retires.
- `dm_rvalid` outside RESP (and outside a load grant cycle) is ignored.
- `retire_cnt` increments by exactly 1 per completed instruction and wraps modulo 2^CNT_W.
- Both c3 and c6 set is illegal; c6 takes priority and the instruction is treated as a store.

## Timing
- Reset values: state IDLE, and `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `wen`, `waddr`, `wdata`, `addr_err`, `retire_cnt` all 0.
- Reset mid-transaction aborts it: no write-back, no retire, and a late response is dropped.
- ALU op latency: `wen` one cycle after acceptance. Throughput is one per cycle, back-to-back.
- Load latency: minimum 2 cycles from acceptance to `wen` (grant and rvalid arriving together in the cycle after acceptance).
- Store latency: acceptance to grant, minimum 1 cycle.
- `wen`, `waddr`, `wdata` and `addr_err` are registered one-cycle pulses. `waddr`/`wdata` hold their last value when `wen` = 0.
- `dm_*` outputs are registered; `dm_req` deasserts the cycle after grant.
- `in_ready` is low from the cycle after a memory accept until the completing cycle.

## Structure
- Shared package `mycpu_pkg`: FSM state encoding (`MW_IDLE`, `MW_REQ`, `MW_RESP`), constant `REG_ZERO` = 5'd0, and the C3/C5/C6 control-bit positions shared with the decode stage.
- One sub-module, `mycpu_wb_reg`: the registered write-back port, holding wen/waddr/wdata with r0 suppression and the retire increment.

## Test plan
- ALU back-to-back: three ADDU results, target 5/6/7, values 1/2/3 on consecutive cycles → `wen` on three consecutive cycles with matching data; `retire_cnt` = 3.
- Load, zero-wait: addr 0x100, target 8; gnt and rvalid arrive together with 0xDEADBEEF → `wen` two cycles after accept, `waddr` = 8, `wdata` = 0xDEADBEEF.
- Store with 3-cycle grant stall: addr 0x204, data 0x12345678 → `dm_req` and `dm_addr`/`dm_wdata` held stable 3 cycles, `in_ready` low, no `wen`.
- Misaligned: LW at 0x102 → no `dm_req`, `addr_err` pulse, no `wen`; `retire_cnt` increments.
- Write to r0: ADDU target 0, result 0xFF → `wen` stays 0; `retire_cnt` increments.
- Reset in RESP: assert `rst` low, then deliver `dm_rvalid` after release → no `wen`, all outputs 0, `in_ready` = 1.
